// File: rtl/pe_result_drain.sv
// pe_result_drain: drains PE result buffers on trigger edges and streams
// every word out with its PE id and buffer address.
// Read path: issue (registered rd_en/addr) -> capture (1-cycle PE latency)
// -> 4-entry FIFO -> valid/ready stream.
module pe_result_drain #(
    parameter int D_WIDTH      = 64,
    parameter int A_PART_WIDTH = 1,
    parameter int B_NUM_WIDTH  = 1,
    parameter int PE_NUM       = 4,
    parameter int PE_ID_WIDTH  = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [PE_NUM-1:0]                    output_trigger_in,
    output logic [PE_NUM-1:0]                    res_rd_en_out,
    output logic [A_PART_WIDTH+B_NUM_WIDTH-1:0]  res_rd_addr_out,
    input  logic [PE_NUM*D_WIDTH-1:0]            res_rd_data_in,
    output logic [D_WIDTH-1:0]                   out_data,
    output logic [PE_ID_WIDTH-1:0]               out_pe_id,
    output logic [A_PART_WIDTH+B_NUM_WIDTH-1:0]  out_addr,
    output logic                                 out_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy_out
);

    localparam int ADDR_W = A_PART_WIDTH + B_NUM_WIDTH;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef struct packed {
        logic [D_WIDTH-1:0]     data;
        logic [PE_ID_WIDTH-1:0] pe;
        logic [ADDR_W-1:0]      addr;
        logic                   last;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DRAIN     = 2'd1,
        S_WAIT_LAST = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [PE_NUM-1:0]      r_trig_prev, r_pending;
    logic [PE_NUM-1:0]      w_edge, w_clr;
    logic [PE_ID_WIDTH-1:0] r_cur_pe, w_sel_pe, w_issue_pe;
    logic [ADDR_W-1:0]      r_addr, w_addr_nxt, w_issue_addr;
    logic                   w_any_pending, w_sel, w_issue, w_room;
    logic [3:0]             w_occ;

    // issue stage (drives the PE read ports) and capture stage
    logic [PE_NUM-1:0]      r_rd_en;
    logic [ADDR_W-1:0]      r_rd_addr;
    logic [PE_ID_WIDTH-1:0] r_rd_pe;
    logic                   r_rd_vld;
    logic                   r_cap_vld;
    logic [PE_ID_WIDTH-1:0] r_cap_pe;
    logic [ADDR_W-1:0]      r_cap_addr;
    logic [D_WIDTH-1:0]     w_cap_data;

    // result FIFO
    entry_t                 r_mem [4];
    logic [1:0]             r_wptr, r_rptr;
    logic [2:0]             r_count;
    logic                   w_push, w_pop;
    entry_t                 w_push_entry, w_head;

    assign w_edge        = output_trigger_in & ~r_trig_prev;
    assign w_any_pending = |r_pending;
    assign w_clr         = w_sel ? (PE_NUM'(1) << w_sel_pe) : '0;

    // Reads issued but not yet popped must fit the FIFO; pop is not credited here.
    assign w_occ  = {1'b0, r_count} + {3'b0, r_rd_vld} + {3'b0, r_cap_vld};
    assign w_room = (w_occ < 4'd4);

    // Lowest-index pending PE wins.
    always_comb begin
        w_sel_pe = '0;
        for (int i = PE_NUM - 1; i >= 0; i--) begin
            if (r_pending[i]) w_sel_pe = PE_ID_WIDTH'(i);
        end
    end

    // Edge capture; a fresh edge beats the clear of the PE being selected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_prev <= '0;
            r_pending   <= '0;
        end else begin
            r_trig_prev <= output_trigger_in;
            r_pending   <= (r_pending & ~w_clr) | w_edge;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and issue control. Selecting a PE also issues its addr 0
    // in the same cycle so a new block starts without an extra bubble.
    always_comb begin
        w_state_nxt  = r_state;
        w_sel        = 1'b0;
        w_issue      = 1'b0;
        w_issue_pe   = r_cur_pe;
        w_issue_addr = r_addr;
        w_addr_nxt   = r_addr;
        case (r_state)
            S_IDLE:  w_sel = w_any_pending;
            S_DRAIN: w_issue = w_room;
            S_WAIT_LAST: begin
                // final read leaves the issue stage -> captured this cycle
                if (!r_rd_vld) begin
                    w_sel = w_any_pending;
                    if (!w_any_pending) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_sel) begin
            w_issue      = w_room;
            w_issue_pe   = w_sel_pe;
            w_issue_addr = '0;
            w_addr_nxt   = '0;
            w_state_nxt  = S_DRAIN;
        end
        if (w_issue) begin
            if (w_issue_addr == LAST_ADDR) begin
                w_addr_nxt  = '0;
                w_state_nxt = S_WAIT_LAST;
            end else begin
                w_addr_nxt  = w_issue_addr + 1'b1;
            end
        end
    end

    // Current PE and address counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_pe <= '0;
            r_addr   <= '0;
        end else begin
            if (w_sel) r_cur_pe <= w_sel_pe;
            r_addr <= w_addr_nxt;
        end
    end

    // Registered read-port drive plus tag for the capture stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_en   <= '0;
            r_rd_addr <= '0;
            r_rd_pe   <= '0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_rd_en  <= w_issue ? (PE_NUM'(1) << w_issue_pe) : '0;
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_rd_addr <= w_issue_addr;
                r_rd_pe   <= w_issue_pe;
            end
        end
    end

    // Capture stage: PE data arrives one cycle after its rd_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_vld  <= 1'b0;
            r_cap_pe   <= '0;
            r_cap_addr <= '0;
        end else begin
            r_cap_vld  <= r_rd_vld;
            r_cap_pe   <= r_rd_pe;
            r_cap_addr <= r_rd_addr;
        end
    end

    // Select the responding PE's data slice.
    always_comb begin
        w_cap_data = '0;
        for (int i = 0; i < PE_NUM; i++) begin
            if (r_cap_pe == PE_ID_WIDTH'(i)) w_cap_data = res_rd_data_in[i*D_WIDTH +: D_WIDTH];
        end
    end

    assign w_push       = r_cap_vld;
    assign w_pop        = (r_count != 3'd0) && out_ready;
    assign w_push_entry = '{data: w_cap_data, pe: r_cap_pe, addr: r_cap_addr,
                            last: (r_cap_addr == LAST_ADDR)};
    assign w_head       = r_mem[r_rptr];

    // FIFO storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_push_entry;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 2'd1;
            if (w_pop)  r_rptr <= r_rptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head drives the stream; fields read zero while empty.
    assign out_valid       = (r_count != 3'd0);
    assign out_data        = out_valid ? w_head.data : '0;
    assign out_pe_id       = out_valid ? w_head.pe   : '0;
    assign out_addr        = out_valid ? w_head.addr : '0;
    assign out_last        = out_valid & w_head.last;
    assign res_rd_en_out   = r_rd_en;
    assign res_rd_addr_out = r_rd_addr;
    assign busy_out        = (r_state != S_IDLE) | r_rd_vld | r_cap_vld | out_valid;

endmodule
